// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, A, B, input busy, done, D, Bout, ovf);
    modport slave  (input start, A, B, output busy, done, D, Bout, ovf);
`else
    modport master (output start, A, B, input busy, done, D, Bout);
    modport slave  (input start, A, B, output busy, done, D, Bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor D = A - B using one full-subtractor cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                resetn,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             capture_s;
    logic             shift_s;
    logic             finish_s;

    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] res_r;
    logic [CW-1:0]    cnt_r;
    logic             bin_r;
    logic [WIDTH-1:0] d_r;
    logic             bout_r;
    logic             busy_r;
    logic             done_r;

    logic             a_s;
    logic             b_s;
    logic             diff_s;
    logic             bin_s;
    logic [WIDTH-1:0] res_s;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_r;
    logic             b_msb_r;
    logic             ovf_r;
`endif

    // Full-subtractor cell on the current LSBs plus the result shift.
    always_comb begin
        a_s    = sa_r[0];
        b_s    = sb_r[0];
        diff_s = a_s ^ b_s ^ bin_r;
        bin_s  = (~a_s & b_s) | (~(a_s ^ b_s) & bin_r);
        res_s  = {diff_s, res_r[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        shift_s   = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s   = RUN;
                    capture_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                shift_s = 1'b1;
                if (cnt_r == LAST_BIT) begin
                    state_s  = DONE;
                    finish_s = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_s   = RUN;
                    capture_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand shift registers, borrow, bit counter and partial result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sa_r  <= {WIDTH{1'b0}};
            sb_r  <= {WIDTH{1'b0}};
            res_r <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
            bin_r <= 1'b0;
        end else if (capture_s) begin
            sa_r  <= bus.A;
            sb_r  <= bus.B;
            res_r <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
            bin_r <= 1'b0;
        end else if (shift_s) begin
            sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
            sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
            res_r <= res_s;
            cnt_r <= cnt_r + CNT_ONE;
            bin_r <= bin_s;
        end else begin
            sa_r  <= sa_r;
            sb_r  <= sb_r;
            res_r <= res_r;
            cnt_r <= cnt_r;
            bin_r <= bin_r;
        end
    end

    // Result registers hold until the next completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_r    <= {WIDTH{1'b0}};
            bout_r <= 1'b0;
        end else if (finish_s) begin
            d_r    <= res_s;
            bout_r <= bin_s;
        end else begin
            d_r    <= d_r;
            bout_r <= bout_r;
        end
    end

    // Status outputs registered from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == RUN);
            done_r <= (state_s == DONE);
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are latched because the shifters lose them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (capture_s) begin
            a_msb_r <= bus.A[WIDTH-1];
            b_msb_r <= bus.B[WIDTH-1];
            ovf_r   <= ovf_r;
        end else if (finish_s) begin
            a_msb_r <= a_msb_r;
            b_msb_r <= b_msb_r;
            ovf_r   <= (a_msb_r != b_msb_r) & (res_s[WIDTH-1] != a_msb_r);
        end else begin
            a_msb_r <= a_msb_r;
            b_msb_r <= b_msb_r;
            ovf_r   <= ovf_r;
        end
    end

    assign bus.ovf = ovf_r;
`endif

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.D    = d_r;
    assign bus.Bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;
    localparam int WIDTH = 8;
    localparam int MAX_WAIT = 30;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_d;
        logic       exp_bout;
        logic       exp_ovf;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Waits for done; n = edges after the accepting edge, busy_ok = busy held until then.
    task automatic wait_done(output int n, output logic busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && n < MAX_WAIT) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input vec_t v);
        int   n;
        logic busy_ok;
        bus.A = v.a;
        bus.B = v.b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.A = ~v.a;
        bus.B = v.a ^ 8'h5A;
        check({tag, " busy_after_accept"}, {31'd0, bus.busy}, 32'd1);
        wait_done(n, busy_ok);
        check({tag, " latency"}, n, WIDTH);
        check({tag, " busy_in_run"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " D"}, {24'd0, bus.D}, {24'd0, v.exp_d});
        check({tag, " Bout"}, {31'd0, bus.Bout}, {31'd0, v.exp_bout});
`ifdef SERIAL_SUB_OVF_EN
        check({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, v.exp_ovf});
`endif
        tick();
        check({tag, " done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, " D_hold"}, {24'd0, bus.D}, {24'd0, v.exp_d});
    endtask

    vec_t vecs [8];

    initial begin
        int   n;
        logic busy_ok;
        logic idle_ok;
        vec_t v;

        checks = 0;
        errors = 0;
        vecs[0] = '{8'd200, 8'd55,  8'd145,  1'b0, 1'b0};
        vecs[1] = '{8'd5,   8'd9,   8'hFC,   1'b1, 1'b0};
        vecs[2] = '{8'h00,  8'h00,  8'h00,   1'b0, 1'b0};
        vecs[3] = '{8'hFF,  8'hFF,  8'h00,   1'b0, 1'b0};
        vecs[4] = '{8'h80,  8'h01,  8'h7F,   1'b0, 1'b1};
        vecs[5] = '{8'h10,  8'h01,  8'h0F,   1'b0, 1'b0};
        vecs[6] = '{8'h00,  8'h01,  8'hFF,   1'b1, 1'b0};
        vecs[7] = '{8'h7F,  8'hFF,  8'h80,   1'b1, 1'b1};

        resetn = 1'b0;
        bus.start = 1'b0;
        bus.A = 8'h00;
        bus.B = 8'h00;
        tick();
        tick();
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst D", {24'd0, bus.D}, 32'd0);
        check("rst Bout", {31'd0, bus.Bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst ovf", {31'd0, bus.ovf}, 32'd0);
`endif
        resetn = 1'b1;
        idle_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.A = 8'(i * 13);
            bus.B = 8'(i * 7);
            tick();
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.D !== 8'h00 || bus.Bout !== 1'b0)
                idle_ok = 1'b0;
        end
        check("idle stable", {31'd0, idle_ok}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Start ignored mid-run, then start held across done for a back-to-back op.
        bus.A = 8'd100;
        bus.B = 8'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.A = 8'd3;
        bus.B = 8'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.A = 8'd7;
        bus.B = 8'd2;
        bus.start = 1'b1;
        n = 0;
        while (bus.done !== 1'b1 && n < MAX_WAIT) begin
            tick();
            n++;
        end
        check("ign done_seen", {31'd0, bus.done}, 32'd1);
        check("ign D", {24'd0, bus.D}, 32'd99);
        check("ign Bout", {31'd0, bus.Bout}, 32'd0);
        tick();
        bus.start = 1'b0;
        check("b2b busy", {31'd0, bus.busy}, 32'd1);
        check("b2b done_drop", {31'd0, bus.done}, 32'd0);
        wait_done(n, busy_ok);
        check("b2b latency", n, WIDTH);
        check("b2b D", {24'd0, bus.D}, 32'd5);
        check("b2b Bout", {31'd0, bus.Bout}, 32'd0);
        tick();

        // Reset mid-run aborts without touching D beyond clearing it.
        bus.A = 8'd50;
        bus.B = 8'd20;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort busy_before", {31'd0, bus.busy}, 32'd1);
        resetn = 1'b0;
        #1;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort D", {24'd0, bus.D}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        check("abort idle", {31'd0, bus.busy}, 32'd0);
        v = '{8'd50, 8'd20, 8'd30, 1'b0, 1'b0};
        run_op("redo", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
